// File: rtl/axi4_burst_slave.sv
// AXI4 burst memory slave: reads give RVALID two cycles after AR, writes give BVALID one cycle after the last beat; RREADY/BREADY low holds outputs.
// Optional WRAP burst support is enabled by defining AXI4_MEM_WRAP_EN; otherwise AxBURST=10 is answered as an error burst.
module axi4_burst_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int EW    = ADDR_WIDTH + 13;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Widened arithmetic so the last-beat address never overflows the address width.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst);
    logic [EW-1:0] start, last, size, len_e;
    logic          err;
    len_e = EW'(len);
    start = EW'(addr);
    size  = (len_e + EW'(1)) << SHIFT;
    last  = start;
    err   = 1'b0;
    case (burst)
      2'b00: last = start;
      2'b01: begin
        last = start + (len_e << SHIFT);
        if (last[EW-1:12] != start[EW-1:12]) err = 1'b1;
      end
      2'b10: begin
`ifdef AXI4_MEM_WRAP_EN
        if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
        last = (start & ~(size - EW'(1))) + size - EW'(BYTES);
`else
        err = 1'b1;
`endif
      end
      default: err = 1'b1;
    endcase
    if ((last >> SHIFT) >= EW'(MEMORY_DEPTH)) err = 1'b1;
    return err;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask, inc;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << SHIFT) - ADDR_WIDTH'(1);
    inc  = addr + ADDR_WIDTH'(BYTES);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[SHIFT +: IDX_W];
  endfunction

  // ---------------- write channel ----------------
  wstate_t               w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst, b_resp;
  logic                  w_err, w_fire, w_final;

  assign w_fire  = WVALID && WREADY;
  assign w_final = WLAST || (w_cnt == w_len);
  assign BRESP   = b_resp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      b_resp  <= 2'b00;
    end else begin
      if (AWVALID && AWREADY) begin
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= burst_err(AWADDR, AWLEN, AWBURST);
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_final)
          b_resp <= (w_err || (WLAST != (w_cnt == w_len))) ? 2'b10 : 2'b00;
      end
      if (BVALID && BREADY) b_resp <= 2'b00;
    end
  end

  // Memory is deliberately unreset so a reset mid-burst keeps earlier beats.
  always_ff @(posedge ACLK) begin
    if (w_fire && !w_err) begin
      for (int i = 0; i < BYTES; i++)
        if (WSTRB[i]) mem[word_idx(w_addr)][i*8 +: 8] <= WDATA[i*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_n;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err, r_last, r_fire;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign r_last   = (r_cnt == r_len);
  assign r_fire   = RVALID && RREADY;
  assign r_addr_n = next_addr(r_addr, r_len, r_burst);
  assign RDATA    = rdata_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    RRESP   = 2'b00;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_next = R_ADDR;
      end
      R_ADDR: r_next = R_DATA;
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = r_last;
        RRESP  = r_err ? 2'b10 : 2'b00;
        if (RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Nonblocking memory read gives pre-write data on a same-cycle collision.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (ARVALID && ARREADY) begin
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_burst <= ARBURST;
        r_cnt   <= '0;
        r_err   <= burst_err(ARADDR, ARLEN, ARBURST);
      end
      if (r_state == R_ADDR)
        rdata_q <= r_err ? '0 : mem[word_idx(r_addr)];
      if (r_fire && !r_last) begin
        r_addr  <= r_addr_n;
        r_cnt   <= r_cnt + 8'd1;
        rdata_q <= r_err ? '0 : mem[word_idx(r_addr_n)];
      end
    end
  end
endmodule
